// File: rtl/div_sched_if.sv
// Request/response and divider-core signal bundle for div_sched.
// The master modport is the scheduler's view. The slave modport is the
// view of the environment, which holds the requesters and the core.
interface div_sched_if #(
  parameter int XLEN = 32,
  parameter int NREQ = 2
);
  // requester side
  logic [NREQ-1:0]            req_valid_i;
  logic [NREQ-1:0]            req_ready_o;
  logic [NREQ-1:0][XLEN-1:0]  req_dividend_i;
  logic [NREQ-1:0][XLEN-1:0]  req_divisor_i;
  logic [NREQ-1:0]            flush_i;
  logic [NREQ-1:0]            rsp_valid_o;
  logic [NREQ-1:0]            rsp_ready_i;
  logic [XLEN-1:0]            rsp_quotient_o;
  logic [XLEN-1:0]            rsp_remainder_o;
  logic                       rsp_dbz_o;
  // divider core side
  logic                       div_start_o;
  logic [XLEN-1:0]            div_dividend_o;
  logic [XLEN-1:0]            div_divisor_o;
  logic                       div_busy_i;
  logic                       div_done_i;
  logic                       div_dbz_i;
  logic [XLEN-1:0]            div_quotient_i;
  logic [XLEN-1:0]            div_remainder_i;

  modport master (
    input  req_valid_i, req_dividend_i, req_divisor_i, flush_i, rsp_ready_i,
    input  div_busy_i, div_done_i, div_dbz_i, div_quotient_i, div_remainder_i,
    output req_ready_o, rsp_valid_o, rsp_quotient_o, rsp_remainder_o, rsp_dbz_o,
    output div_start_o, div_dividend_o, div_divisor_o
  );

  modport slave (
    output req_valid_i, req_dividend_i, req_divisor_i, flush_i, rsp_ready_i,
    output div_busy_i, div_done_i, div_dbz_i, div_quotient_i, div_remainder_i,
    input  req_ready_o, rsp_valid_o, rsp_quotient_o, rsp_remainder_o, rsp_dbz_o,
    input  div_start_o, div_dividend_o, div_divisor_o
  );
endinterface

// File: rtl/div_sched.sv
// Round-robin scheduler that shares one iterative unsigned divider among
// NREQ requesters. A divisor of zero is answered without using the core.
// A one-entry cache answers a repeat of the last computed pair without
// using the core.
module div_sched #(
  parameter int XLEN     = 32,
  parameter int NREQ     = 2,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  div_sched_if.master   bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t             r_state;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_owner;
  logic               r_killed;
  logic               r_start;
  logic [XLEN-1:0]    r_dvd;
  logic [XLEN-1:0]    r_dvs;
  logic [XLEN-1:0]    r_quo;
  logic [XLEN-1:0]    r_rem;
  logic               r_dbz;
  logic [NREQ-1:0]    r_rsp_valid;
  logic               r_c_vld;
  logic [XLEN-1:0]    r_c_dvd;
  logic [XLEN-1:0]    r_c_dvs;
  logic [XLEN-1:0]    r_c_quo;
  logic [XLEN-1:0]    r_c_rem;
  logic               r_c_dbz;

  logic [NREQ-1:0]    w_elig;
  logic               w_gnt_vld;
  logic [PW-1:0]      w_gnt_idx;
  logic [PW-1:0]      w_idx;
  logic [NREQ-1:0]    w_gnt_onehot;
  logic [NREQ-1:0]    w_own_onehot;
  logic [XLEN-1:0]    w_sel_dvd;
  logic [XLEN-1:0]    w_sel_dvs;
  logic               w_hit;
  logic               w_own_flush;
  logic               w_own_ready;

  // Pointer successor, wrapping at NREQ-1 for non-power-of-two counts.
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    if (int'(idx) == NREQ - 1) return '0;
    return idx + PW'(1);
  endfunction

  // Round-robin pick. Scanning downward leaves the requester closest to the pointer as the winner.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    w_elig    = bus.req_valid_i & ~bus.flush_i;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % NREQ);
      if (w_elig[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
  end

  assign w_gnt_onehot = NREQ'(1) << w_gnt_idx;
  assign w_own_onehot = NREQ'(1) << r_owner;
  assign w_sel_dvd    = bus.req_dividend_i[w_gnt_idx];
  assign w_sel_dvs    = bus.req_divisor_i[w_gnt_idx];
  assign w_hit        = CACHE_EN && r_c_vld && (w_sel_dvd == r_c_dvd) && (w_sel_dvs == r_c_dvs);
  assign w_own_flush  = bus.flush_i[r_owner];
  assign w_own_ready  = bus.rsp_ready_i[r_owner];

  // Ready is gated by reset so that every output reads zero while reset is held.
  assign bus.req_ready_o     = (rst_ni && r_state == IDLE && w_gnt_vld) ? w_gnt_onehot : '0;
  assign bus.rsp_valid_o     = r_rsp_valid;
  assign bus.rsp_quotient_o  = r_quo;
  assign bus.rsp_remainder_o = r_rem;
  assign bus.rsp_dbz_o       = r_dbz;
  assign bus.div_start_o     = r_start;
  assign bus.div_dividend_o  = r_dvd;
  assign bus.div_divisor_o   = r_dvs;

  // Scheduler FSM: accept, bypass or start the core, wait for done, then hand back the result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_killed    <= 1'b0;
      r_start     <= 1'b0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_dbz       <= 1'b0;
      r_rsp_valid <= '0;
      r_c_vld     <= 1'b0;
      r_c_dvd     <= '0;
      r_c_dvs     <= '0;
      r_c_quo     <= '0;
      r_c_rem     <= '0;
      r_c_dbz     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_owner  <= w_gnt_idx;
            r_dvd    <= w_sel_dvd;
            r_dvs    <= w_sel_dvs;
            r_killed <= 1'b0;
            if (w_sel_dvs == '0) begin
              r_quo       <= '1;
              r_rem       <= w_sel_dvd;
              r_dbz       <= 1'b1;
              r_rsp_valid <= w_gnt_onehot;
              r_state     <= RESP;
            end else if (w_hit) begin
              r_quo       <= r_c_quo;
              r_rem       <= r_c_rem;
              r_dbz       <= r_c_dbz;
              r_rsp_valid <= w_gnt_onehot;
              r_state     <= RESP;
            end else begin
              // The pulse goes out in the first START cycle when the core is free.
              r_start <= ~bus.div_busy_i;
              r_state <= START;
            end
          end
        end
        START: begin
          if (w_own_flush) begin
            r_start <= 1'b0;
            r_ptr   <= next_idx(r_owner);
            r_state <= IDLE;
          end else if (r_start) begin
            r_start <= 1'b0;
            r_state <= WAIT;
          end else if (!bus.div_busy_i) begin
            r_start <= 1'b1;
          end
        end
        WAIT: begin
          if (w_own_flush) r_killed <= 1'b1;
          if (bus.div_done_i) begin
            r_quo   <= bus.div_quotient_i;
            r_rem   <= bus.div_remainder_i;
            r_dbz   <= bus.div_dbz_i;
            r_c_vld <= 1'b1;
            r_c_dvd <= r_dvd;
            r_c_dvs <= r_dvs;
            r_c_quo <= bus.div_quotient_i;
            r_c_rem <= bus.div_remainder_i;
            r_c_dbz <= bus.div_dbz_i;
            if (r_killed || w_own_flush) begin
              r_ptr   <= next_idx(r_owner);
              r_state <= IDLE;
            end else begin
              r_rsp_valid <= w_own_onehot;
              r_state     <= RESP;
            end
          end
        end
        RESP: begin
          // A flush in the same cycle as ready is treated as a consumed response.
          if (w_own_ready || w_own_flush) begin
            r_rsp_valid <= '0;
            r_ptr       <= next_idx(r_owner);
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a simple fixed-latency divider core model.
module tb_div_sched;
  localparam int XLEN = 32;
  localparam int NREQ = 2;
  localparam int LAT  = 34;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   start_cnt;
  int   saved;

  logic [XLEN-1:0] m_a;
  logic [XLEN-1:0] m_b;
  int              m_cnt;

  div_sched_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

  div_sched #(.XLEN(XLEN), .NREQ(NREQ), .CACHE_EN(1'b1)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: latches operands on a start pulse and reports done LAT cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.div_busy_i      <= 1'b0;
      bus.div_done_i      <= 1'b0;
      bus.div_dbz_i       <= 1'b0;
      bus.div_quotient_i  <= '0;
      bus.div_remainder_i <= '0;
      m_cnt               <= 0;
      m_a                 <= '0;
      m_b                 <= '0;
    end else begin
      bus.div_done_i <= 1'b0;
      if (bus.div_start_o && !bus.div_busy_i) begin
        bus.div_busy_i <= 1'b1;
        m_cnt          <= LAT - 1;
        m_a            <= bus.div_dividend_o;
        m_b            <= bus.div_divisor_o;
      end else if (bus.div_busy_i) begin
        if (m_cnt == 0) begin
          bus.div_busy_i      <= 1'b0;
          bus.div_done_i      <= 1'b1;
          bus.div_dbz_i       <= (m_b == '0);
          bus.div_quotient_i  <= (m_b == '0) ? '1 : m_a / m_b;
          bus.div_remainder_i <= (m_b == '0) ? m_a : m_a % m_b;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // Counts start pulses seen by the core.
  always @(posedge clk) if (bus.div_start_o) start_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int idx, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.req_dividend_i[idx] = a;
    bus.req_divisor_i[idx]  = b;
    bus.req_valid_i[idx]    = 1'b1;
    #1;
    chk("req_ready", bus.req_ready_o, NREQ'(1) << idx);
    tick();
    bus.req_valid_i[idx] = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (bus.rsp_valid_o == '0 && n < 80) begin
      tick();
      n++;
    end
    chk(tag, (n < 80), 1);
  endtask

  task automatic handshake(input int idx);
    bus.rsp_ready_i = NREQ'(1) << idx;
    tick();
    bus.rsp_ready_i = '0;
    chk("rsp_drop", bus.rsp_valid_o, 0);
  endtask

  task automatic chk_rsp(input int idx, input logic [XLEN-1:0] q, input logic [XLEN-1:0] r, input logic d);
    chk("rsp_valid", bus.rsp_valid_o, NREQ'(1) << idx);
    chk("rsp_quo", bus.rsp_quotient_o, q);
    chk("rsp_rem", bus.rsp_remainder_o, r);
    chk("rsp_dbz", bus.rsp_dbz_o, d);
  endtask

  task automatic chk_all_zero();
    chk("rst_req_ready", bus.req_ready_o, 0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_start", bus.div_start_o, 0);
    chk("rst_quo", bus.rsp_quotient_o, 0);
    chk("rst_rem", bus.rsp_remainder_o, 0);
    chk("rst_dbz", bus.rsp_dbz_o, 0);
    chk("rst_div_dvd", bus.div_dividend_o, 0);
    chk("rst_div_dvs", bus.div_divisor_o, 0);
  endtask

  initial begin
    int seen;
    int n;
    int exp_idx;
    checks             = 0;
    errors             = 0;
    start_cnt          = 0;
    rst_n              = 1'b0;
    bus.req_valid_i    = '0;
    bus.req_dividend_i = '0;
    bus.req_divisor_i  = '0;
    bus.flush_i        = '0;
    bus.rsp_ready_i    = '0;

    // Reset: outputs zero even with requests pending.
    tick();
    bus.req_valid_i = 2'b11;
    tick();
    chk_all_zero();
    bus.req_valid_i = '0;
    rst_n = 1'b1;
    tick();

    // Single miss: 100/7 from req0.
    issue(0, 32'd100, 32'd7);
    chk("miss_start", bus.div_start_o, 1);
    chk("miss_op_dvd", bus.div_dividend_o, 100);
    chk("miss_op_dvs", bus.div_divisor_o, 7);
    tick();
    chk("miss_start_pulse", bus.div_start_o, 0);
    wait_rsp("miss_timeout");
    chk_rsp(0, 32'd14, 32'd2, 1'b0);
    // Backpressure: bus steady and no new grant.
    bus.req_valid_i[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", bus.rsp_valid_o, 2'b01);
      chk("bp_quo", bus.rsp_quotient_o, 14);
      chk("bp_no_grant", bus.req_ready_o, 0);
    end
    bus.req_valid_i[1] = 1'b0;
    handshake(0);

    // Cache hit: same pair from req1.
    saved = start_cnt;
    issue(1, 32'd100, 32'd7);
    chk_rsp(1, 32'd14, 32'd2, 1'b0);
    chk("hit_no_start", bus.div_start_o, 0);
    handshake(1);
    chk("hit_start_cnt", start_cnt, saved);
    // Different divisor must miss.
    issue(0, 32'd100, 32'd9);
    chk("miss2_start", bus.div_start_o, 1);
    wait_rsp("miss2_timeout");
    chk_rsp(0, 32'd11, 32'd1, 1'b0);
    handshake(0);

    // Divisor zero bypass.
    saved = start_cnt;
    issue(0, 32'hDEADBEEF, 32'd0);
    chk_rsp(0, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1);
    handshake(0);
    issue(1, 32'd1, 32'd0);
    chk_rsp(1, 32'hFFFFFFFF, 32'd1, 1'b1);
    handshake(1);
    chk("dbz_no_start", start_cnt, saved);

    // Round robin with both requesters held valid.
    bus.req_dividend_i[0] = 32'd1000;
    bus.req_divisor_i[0]  = 32'd3;
    bus.req_dividend_i[1] = 32'd77;
    bus.req_divisor_i[1]  = 32'd10;
    bus.req_valid_i       = 2'b11;
    #1;
    for (int g = 0; g < 4; g++) begin
      exp_idx = g % 2;
      chk("rr_grant", bus.req_ready_o, NREQ'(1) << exp_idx);
      tick();
      wait_rsp("rr_timeout");
      if (exp_idx == 0) chk_rsp(0, 32'd333, 32'd1, 1'b0);
      else              chk_rsp(1, 32'd7, 32'd7, 1'b0);
      if (g == 0) begin
        for (int i = 0; i < 3; i++) begin
          tick();
          chk("rr_bp_quo", bus.rsp_quotient_o, 333);
          chk("rr_bp_no_grant", bus.req_ready_o, 0);
        end
      end
      handshake(exp_idx);
    end
    bus.req_valid_i = '0;

    // Flush in WAIT: response dropped, cache still updated.
    issue(0, 32'd500, 32'd6);
    chk("fl_start", bus.div_start_o, 1);
    repeat (5) tick();
    bus.flush_i[0] = 1'b1;
    tick();
    bus.flush_i[0] = 1'b0;
    seen = 0;
    n = 0;
    while (bus.div_busy_i && n < 80) begin
      tick();
      n++;
      if (bus.rsp_valid_o != '0) seen = 1;
    end
    chk("fl_done_timeout", (n < 80), 1);
    repeat (3) begin
      tick();
      if (bus.rsp_valid_o != '0) seen = 1;
    end
    chk("fl_no_rsp", seen, 0);
    saved = start_cnt;
    issue(0, 32'd500, 32'd6);
    chk_rsp(0, 32'd83, 32'd2, 1'b0);
    handshake(0);
    chk("fl_hit_no_start", start_cnt, saved);

    // Reset mid-WAIT clears everything, including the cache.
    issue(1, 32'd40, 32'd3);
    chk("rw_start", bus.div_start_o, 1);
    repeat (5) tick();
    bus.req_valid_i = 2'b11;
    rst_n = 1'b0;
    #1;
    chk_all_zero();
    tick();
    bus.req_valid_i = '0;
    rst_n = 1'b1;
    tick();
    issue(0, 32'd500, 32'd6);
    chk("rw_cache_cleared", bus.div_start_o, 1);
    wait_rsp("rw_timeout");
    chk_rsp(0, 32'd83, 32'd2, 1'b0);
    handshake(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_sched.md
# div_sched

Round-robin scheduler that shares one iterative unsigned divider core (`divu_int`) between `NREQ` requesters, such as the execute-stage ALU and a second issue port or debug path. It accepts one unsigned dividend/divisor pair at a time, sequences the core's start/done handshake, and returns quotient, remainder and divide-by-zero status to the winning requester. A one-entry result cache and a divisor-zero bypass answer repeated and by-zero requests in one cycle without starting the core. Sign correction and RISC-V DIV/REM result selection remain in each requester.

## Interface
Parameters:
- `XLEN`, 32, operand/result width.
- `NREQ`, 2, number of requesters (≥2).
- `CACHE_EN`, 1, enables the one-entry result cache (0 means every nonzero-divisor request starts the core).

Ports:
- `clk_i` input 1: clock, single clock domain.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `req_valid_i` input [NREQ]: request valid, per requester.
- `req_ready_o` output [NREQ]: request accepted this cycle (one-hot or zero).
- `req_dividend_i` input [NREQ][XLEN]: unsigned dividend.
- `req_divisor_i` input [NREQ][XLEN]: unsigned divisor.
- `flush_i` input [NREQ]: kill the requester's in-flight or pending operation.
- `rsp_valid_o` output [NREQ]: response valid, one-hot or zero.
- `rsp_ready_i` input [NREQ]: response consumed.
- `rsp_quotient_o` output XLEN: shared result bus.
- `rsp_remainder_o` output XLEN: shared result bus.
- `rsp_dbz_o` output 1: divisor was zero.
- `div_start_o` output 1: single-cycle start pulse to the core.
- `div_dividend_o`, `div_divisor_o` output XLEN: registered operands to the core, stable from start until done.
- `div_busy_i`, `div_done_i`, `div_dbz_i` input 1: core status. `div_done_i` is a single-cycle pulse.
- `div_quotient_i`, `div_remainder_i` input XLEN: core results, valid with `div_done_i`.

## Operation
States: `IDLE`, `START`, `WAIT`, `RESP`.

**Reset**
- State is `IDLE`; priority pointer is 0; cache is invalid.
- All outputs are 0. This includes `req_ready_o`, `rsp_valid_o`, `div_start_o`, the result bus and the operand registers.

**IDLE**
- Grant goes to the first requester with `req_valid_i & ~flush_i`, searching from the pointer and wrapping at `NREQ-1` to 0.
- `req_ready_o[grant]` is driven combinationally in `IDLE` only.
- On acceptance, the scheduler latches the operands and the owner index, then evaluates in order:
  - **Divisor zero:** quotient = all ones, remainder = dividend, dbz = 1. Next state `RESP`.
  - **Cache hit:** `CACHE_EN`, cache valid, and dividend and divisor both equal the cached pair. Load the cached results. Next state `RESP`.
  - **Otherwise:** next state `START`.

**START**
- `div_start_o = 1` in the cycle the state is `START` and `div_busy_i = 0`; the state then moves to `WAIT`.
- While `div_busy_i = 1`, the scheduler holds in `START` and does not pulse.

**WAIT**
- On `div_done_i`, capture the quotient, remainder and `div_dbz_i`.
- Write the cache: operands, results, valid = 1.
- Next state is `RESP`, or `IDLE` if the operation was killed.

**RESP**
- `rsp_valid_o[owner] = 1` and the bus holds steady until `rsp_ready_i[owner]`.
- After the handshake, the state returns to `IDLE` and the pointer becomes (owner+1) mod `NREQ`.

**Flush (owner's `flush_i`)**
- In `START`: go to `IDLE` with no pulse; the pointer advances.
- In `WAIT`: set the `killed` flag, continue until done, update the cache, drop the response, then go to `IDLE`.
- In `RESP`: drop the response (`rsp_valid_o` falls next cycle) and go to `IDLE`.
- Flush of a non-owner has no effect. A flush in the same cycle as `rsp_ready_i` counts as consumed.

**Other rules**
- Cache is never invalidated except by reset. It holds unsigned results only, so it is correct for any opcode mix.
- A `div_done_i` pulse outside `WAIT` is ignored.

## Timing
- Request accepted at cycle T (`req_valid_i & req_ready_o`).
- Bypass or cache hit: `rsp_valid_o` at T+1.
- Miss with the core idle: `div_start_o` at T+1, `rsp_valid_o` in the cycle after `div_done_i`.
- Earliest next acceptance is the cycle after the response handshake. Only one operation is outstanding at a time.
- `rsp_*` and `div_*` outputs are registered. `req_ready_o` is combinational from `req_valid_i`, `flush_i` and state.
- Asserting reset mid-operation returns the block to the reset condition immediately. The core is reset by the same `rst_ni`.

## Test plan
- **Single miss:** req0 100/7 with the core model at 34-cycle latency. Require `div_start_o` one cycle after acceptance and a response quotient 14, remainder 2, dbz 0 to req0 only.
- **Cache hit:** repeat 100/7 from req1. Require `rsp_valid_o[1]` at T+1 with quotient 14, remainder 2, and no `div_start_o`. Then send 100/9 and require a miss (start pulse).
- **Divisor zero:** req0 0xDEADBEEF/0. Require a response at T+1 with quotient 0xFFFFFFFF, remainder 0xDEADBEEF, dbz 1, and no start.
- **Round-robin:** hold req0 and req1 valid continuously with distinct operands. Require grants alternating 0,1,0,1. A backpressured `rsp_ready_i` keeps the bus stable and blocks new grants.
- **Flush in WAIT:** flush req0 mid-divide. Require no `rsp_valid_o[0]` and a return to `IDLE` after done. A repeat of the same operands afterwards is a cache hit.
- **Reset mid-WAIT:** assert `rst_ni` low. Require all outputs 0 immediately and, after release, the cache invalid (the same operands cause a start pulse).
